// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multicycle sequencer for the MIPS core. Each instruction goes through FETCH,
//   DECODE, EXEC1 and, for loads and stores, EXEC2. The block drives the Avalon-MM
//   read/write strobes, the IR load enable and the PC/register-file commit pulses.
//   A stall watchdog sends the block to HALT, with bus_error set, when a bus access
//   waits too long.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   waitrequest  Avalon-MM waitrequest; an access completes in a cycle where it is 0
//   opcode       instr[31:26] from the instruction register
//   wb_en        decoder flag: a non-memory instruction writes the register file
//   pc_is_zero   PC == 0 (the halt address)
//   mem_read     Avalon read strobe
//   mem_write    Avalon write strobe
//   addr_sel     0 = PC (fetch), 1 = ALU result (data access)
//   ir_write     IR load enable
//   pc_write     PC commit pulse, one per retired instruction
//   reg_write    register-file write pulse
//   active       1 until HALT is reached (also forced to 1 while reset is high)
//   bus_error    sticky stall-timeout flag
//   state        FETCH=0, DECODE=1, EXEC1=2, EXEC2=3, HALT=4
//   retired      count of retired instructions; wraps silently
module mips_multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [5:0]  opcode,
  input  logic        wb_en,
  input  logic        pc_is_zero,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        active,
  output logic        bus_error,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec1  = 3'd2,
    StExec2  = 3'd3,
    StHalt   = 3'd4
  } state_e;

  localparam int unsigned CntW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxWaitCnt = CntW'(MAX_WAIT);

  state_e          state_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [31:0]     retired_q;
  logic            bus_error_q;

  logic is_load, is_store, is_mem;
  logic timeout;
  logic fetch_entry;
  logic halt_fetch;

  always_comb begin
    is_load  = opcode inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
    is_store = opcode inside {6'h28, 6'h29, 6'h2B};
    is_mem   = is_load | is_store;
  end

  // wait_cnt is cleared on every state change and counts each stalled cycle, so a
  // zero count in FETCH identifies the entry cycle; pc_is_zero matters only there.
  assign fetch_entry = (wait_cnt_q == '0);
  assign halt_fetch  = fetch_entry & pc_is_zero;
  assign timeout     = waitrequest & (wait_cnt_q == MaxWaitCnt);

  // Strobe decode; reset masks everything so an interrupted access is abandoned.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          if (!halt_fetch && !timeout) begin
            mem_read = 1'b1;
            ir_write = ~waitrequest;
          end
        end
        StExec1: begin
          if (!is_mem) begin
            pc_write  = 1'b1;
            reg_write = wb_en;
          end
        end
        StExec2: begin
          if (!timeout) begin
            addr_sel  = 1'b1;
            mem_read  = is_load;
            mem_write = is_store;
            if (!waitrequest) begin
              pc_write  = 1'b1;
              reg_write = is_load;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      wait_cnt_q  <= '0;
      retired_q   <= '0;
      bus_error_q <= 1'b0;
    end else begin
      if (pc_write) retired_q <= retired_q + 32'd1;
      unique case (state_q)
        StFetch: begin
          if (halt_fetch) begin
            state_q <= StHalt;
          end else if (timeout) begin
            state_q     <= StHalt;
            bus_error_q <= 1'b1;
            wait_cnt_q  <= '0;
          end else if (waitrequest) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end else begin
            state_q    <= StDecode;
            wait_cnt_q <= '0;
          end
        end
        StDecode: state_q <= StExec1;
        StExec1:  state_q <= is_mem ? StExec2 : StFetch;
        StExec2: begin
          if (timeout) begin
            state_q     <= StHalt;
            bus_error_q <= 1'b1;
            wait_cnt_q  <= '0;
          end else if (waitrequest) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end else begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
          end
        end
        StHalt:   state_q <= StHalt;
        // Unused encodings fall into HALT rather than running wild.
        default:  state_q <= StHalt;
      endcase
    end
  end

  assign active    = reset | (state_q != StHalt);
  assign bus_error = bus_error_q;
  assign state     = state_q;
  assign retired   = retired_q;

endmodule
